// File: rtl/seq_divider_ctrl.sv
// seq_divider_ctrl
//   Sequential unsigned restoring divider. Once a division is accepted it
//   resolves one quotient bit per clock, MSB first. A zero divisor
//   completes in a single cycle and returns a flagged, saturated result.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request a division (accepted when ready=1)
//   dividend     unsigned dividend, sampled on the accepting edge
//   divisor      unsigned divisor, sampled on the accepting edge
//   ready        IDLE or DONE: a start will be accepted
//   busy         division in progress (RUN)
//   done         one-cycle pulse, results valid
//   quotient     registered quotient (all ones on divide-by-zero)
//   remainder    registered remainder (dividend on divide-by-zero)
//   div_by_zero  registered flag: last accepted divisor was zero
module seq_divider_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH:0]   r_prem;
  logic [WIDTH-1:0] r_qwork;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dz;

  logic             w_accept;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH:0]   w_prem_next;
  logic [WIDTH-1:0] w_q_next;

  assign w_accept    = start & ready;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dz;

  // One restoring row. The partial remainder is always below the divisor,
  // so its low WIDTH bits carry it in full; the extra bit of the shifted
  // value keeps the trial exact for divisors >= 2^(WIDTH-1).
  always_comb begin
    w_shift           = {r_prem[WIDTH-1:0], r_dividend[r_count]};
    w_ge              = (w_shift >= {1'b0, r_divisor});
    w_diff            = w_shift - {1'b0, r_divisor};
    w_prem_next       = w_ge ? w_diff : w_shift;
    w_q_next          = r_qwork;
    w_q_next[r_count] = w_ge;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (start)                w_next = (divisor == '0) ? S_DONE : S_RUN;
        else if (r_state == S_DONE) w_next = S_IDLE;
      end
      S_RUN:   if (r_count == '0) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    ready = (r_state == S_IDLE) || (r_state == S_DONE);
    busy  = (r_state == S_RUN);
    done  = (r_state == S_DONE);
  end

  // Datapath. Quotient and remainder outputs are written only when a result
  // completes, so the working bits never show outside the core registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_prem      <= '0;
      r_qwork     <= '0;
      r_count     <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dz        <= 1'b0;
    end else if (w_accept) begin
      r_dividend <= dividend;
      r_divisor  <= divisor;
      r_prem     <= '0;
      r_qwork    <= '0;
      r_count    <= CW'(WIDTH - 1);
      r_dz       <= 1'b0;
      if (divisor == '0) begin
        r_quotient  <= '1;
        r_remainder <= dividend;
        r_dz        <= 1'b1;
      end
    end else if (r_state == S_RUN) begin
      r_prem  <= w_prem_next;
      r_qwork <= w_q_next;
      if (r_count == '0) begin
        r_quotient  <= w_q_next;
        r_remainder <= w_prem_next[WIDTH-1:0];
      end else begin
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_divider_ctrl.sv
// Self-checking bench for seq_divider_ctrl (WIDTH=4). Expected results are
// pushed to a scoreboard queue when a division is issued and popped when
// the DUT raises done.
module tb_seq_divider_ctrl;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  seq_divider_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == 0) begin
      e.q  = 4'hF;
      e.r  = a;
      e.dz = 1'b1;
    end else begin
      e.q  = a / b;
      e.r  = a % b;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Drive one request for a single edge; returns #1 after the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb.push_back(model(a, b));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Advance at least one edge, until done or the cycle budget expires.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = (busy === 1'b1) ? 1 : 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (busy === 1'b1) bcnt++;
    end while (done !== 1'b1 && lat < 40);
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (ready !== 1'b1)  $display("FAIL reset_ready got=%b exp=1", ready);  else n_pass++;
    n_total++; if (busy !== 1'b0)   $display("FAIL reset_busy got=%b exp=0", busy);    else n_pass++;
    n_total++; if (done !== 1'b0)   $display("FAIL reset_done got=%b exp=0", done);    else n_pass++;
    n_total++; if ({quotient, remainder, div_by_zero} !== '0)
      $display("FAIL reset_results got=q%0d r%0d dz%b exp=0", quotient, remainder, div_by_zero);
    else n_pass++;
    // Release and start in the same cycle: the release edge accepts it.
    rst_n = 1'b1;
    issue(4'd6, 4'd2);
    n_total++; if (busy !== 1'b1) $display("FAIL release_accept busy got=%b exp=1", busy); else n_pass++;
    begin
      int lat, bc;
      wait_done(lat, bc);
      e = sb.pop_front();
      n_total++; if (quotient !== e.q) $display("FAIL release_q got=%0d exp=%0d", quotient, e.q); else n_pass++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int   lat, bc;
    exp_t e;
    issue(4'd13, 4'd4);
    n_total++; if (ready !== 1'b0) $display("FAIL run_ready got=%b exp=0", ready); else n_pass++;
    wait_done(lat, bc);
    e = sb.pop_front();
    n_total++; if (lat !== 4)  $display("FAIL basic_latency got=%0d exp=4", lat); else n_pass++;
    n_total++; if (bc !== 4)   $display("FAIL basic_busy_cycles got=%0d exp=4", bc); else n_pass++;
    n_total++; if (quotient !== e.q || quotient !== 4'd3)
      $display("FAIL basic_q got=%0d exp=3", quotient); else n_pass++;
    n_total++; if (remainder !== e.r || remainder !== 4'd1)
      $display("FAIL basic_r got=%0d exp=1", remainder); else n_pass++;
    n_total++; if (div_by_zero !== 1'b0) $display("FAIL basic_dz got=%b exp=0", div_by_zero); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (done !== 1'b0) $display("FAIL done_pulse_width got=%b exp=0", done); else n_pass++;
    dividend = 4'd0; divisor = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (quotient !== 4'd3 || remainder !== 4'd1)
      $display("FAIL result_hold got=q%0d r%0d exp=q3 r1", quotient, remainder); else n_pass++;
  endtask

  task automatic test_directed();
    logic [W-1:0] av[3] = '{4'd15, 4'd15, 4'd0};
    logic [W-1:0] bv[3] = '{4'd9, 4'd15, 4'd3};
    for (int i = 0; i < 3; i++) begin
      int   lat, bc;
      exp_t e;
      issue(av[i], bv[i]);
      wait_done(lat, bc);
      e = sb.pop_front();
      n_total++; if (quotient !== e.q || remainder !== e.r)
        $display("FAIL directed_%0d_%0d got=q%0d r%0d exp=q%0d r%0d", av[i], bv[i], quotient, remainder, e.q, e.r);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div_zero();
    int   lat, bc;
    exp_t e;
    issue(4'd7, 4'd0);
    n_total++; if (done !== 1'b1) $display("FAIL dz_latency done got=%b exp=1", done); else n_pass++;
    e = sb.pop_front();
    n_total++; if (quotient !== e.q || remainder !== e.r || quotient !== 4'd15 || remainder !== 4'd7)
      $display("FAIL dz_result got=q%0d r%0d exp=q15 r7", quotient, remainder); else n_pass++;
    n_total++; if (div_by_zero !== 1'b1) $display("FAIL dz_flag got=%b exp=1", div_by_zero); else n_pass++;
    @(posedge clk); #1;
    issue(4'd7, 4'd2);
    n_total++; if (div_by_zero !== 1'b0) $display("FAIL dz_clear got=%b exp=0", div_by_zero); else n_pass++;
    wait_done(lat, bc);
    e = sb.pop_front();
    n_total++; if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz)
      $display("FAIL dz_next got=q%0d r%0d dz%b exp=q%0d r%0d dz%b",
               quotient, remainder, div_by_zero, e.q, e.r, e.dz);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int   lat, bc;
    exp_t e;
    dividend = 4'd12; divisor = 4'd5; start = 1'b1;
    sb.push_back(model(4'd12, 4'd5));
    @(posedge clk); #1;
    // start stays high through RUN; new operands must be ignored until DONE.
    dividend = 4'd9; divisor = 4'd3;
    sb.push_back(model(4'd9, 4'd3));
    wait_done(lat, bc);
    e = sb.pop_front();
    n_total++; if (lat !== 4) $display("FAIL b2b_first_latency got=%0d exp=4", lat); else n_pass++;
    n_total++; if (quotient !== e.q || remainder !== e.r)
      $display("FAIL b2b_first got=q%0d r%0d exp=q%0d r%0d", quotient, remainder, e.q, e.r); else n_pass++;
    wait_done(lat, bc);
    start = 1'b0;
    e = sb.pop_front();
    n_total++; if (lat !== 5) $display("FAIL b2b_spacing got=%0d exp=5", lat); else n_pass++;
    n_total++; if (quotient !== e.q || remainder !== e.r)
      $display("FAIL b2b_second got=q%0d r%0d exp=q%0d r%0d", quotient, remainder, e.q, e.r); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    int   lat, bc;
    int   seen;
    exp_t e;
    issue(4'd14, 4'd3);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    void'(sb.pop_front());
    n_total++; if ({quotient, remainder, div_by_zero} !== '0 || busy !== 1'b0 || ready !== 1'b1 || done !== 1'b0)
      $display("FAIL async_reset got=q%0d r%0d dz%b busy%b ready%b done%b exp=0 0 0 0 1 0",
               quotient, remainder, div_by_zero, busy, ready, done);
    else n_pass++;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    n_total++; if (seen !== 0) $display("FAIL abort_no_done got=%0d exp=0", seen); else n_pass++;
    rst_n = 1'b1;
    issue(4'd14, 4'd3);
    wait_done(lat, bc);
    e = sb.pop_front();
    n_total++; if (lat !== 4) $display("FAIL post_reset_latency got=%0d exp=4", lat); else n_pass++;
    n_total++; if (quotient !== e.q || remainder !== e.r)
      $display("FAIL post_reset got=q%0d r%0d exp=q%0d r%0d", quotient, remainder, e.q, e.r); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_sweep();
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        int   lat, bc;
        exp_t e;
        issue(W'(a), W'(b));
        if (done !== 1'b1) wait_done(lat, bc);
        e = sb.pop_front();
        n_total++;
        if (done !== 1'b1 || quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz)
          $display("FAIL sweep_%0d_%0d got=q%0d r%0d dz%b done%b exp=q%0d r%0d dz%b",
                   a, b, quotient, remainder, div_by_zero, done, e.q, e.r, e.dz);
        else n_pass++;
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_directed();
    test_div_zero();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep();
    n_total++; if (sb.size() !== 0) $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
